unbinding_op: RTL and testbench
===============================

// Module: unbinding_op
// PURPOSE
// - Inverse of the permutation binding step: recovers the original HV from a bound HV
//   by circular rotation opposite to binding.
// - Binding rotates toward MSB by k: out[i] = in[(i-k) mod N].
// - Unbinding rotates toward LSB by k: out[i] = in[(i+k) mod N].
// - Area-lean, multi-cycle: rotates at most STEP positions per cycle instead of a full
//   barrel shifter. Sits on the query path between the bound-HV source and the
//   associative-memory compare.
// PARAMETERS
// - HV_LENGTH  1024  hypervector width N in bits
// - SHIFT_W    6     width of shift_amount; k range 0..2^SHIFT_W-1
// - STEP       8     max rotate positions per cycle, 1 <= STEP <= 2^SHIFT_W-1
// PORTS
// - clk_i               in   1          clock, single domain
// - rst_ni              in   1          asynchronous, active-low reset
// - bound_hv_in         in   HV_LENGTH  bound HV, sampled on the accepted start
// - start_op            in   1          start request, single-cycle pulse or level
// - shift_binding_mode  in   1          1: unbind by shift_amount; 0: pass-through (k=0)
// - shift_amount        in   SHIFT_W    k, sampled on the accepted start
// - unbound_hv_out      out  HV_LENGTH  result register, held until next completion
// - out_ready           out  1          1-cycle pulse, result valid in unbound_hv_out
// - busy                out  1          high while a multi-cycle rotation is in progress
// BEHAVIOUR
// - Reset: unbound_hv_out='0, out_ready=0, busy=0, work_q='0, rem_q=0, state=IDLE.
// - FSM states:
//   - IDLE   -> ROTATE on accept if k_eff > STEP, else stays IDLE.
//   - ROTATE -> IDLE when the final step is performed.
// - Accept: start_op=1 while state=IDLE. Then k_eff = shift_binding_mode ? shift_amount : 0.
// - Per step: s = min(STEP, remaining). Rotate right by s; remaining -= s.
// - Accept edge performs the first step on bound_hv_in:
//   - If remaining reaches 0: write unbound_hv_out, out_ready<=1.
//   - Else: write work_q and rem_q, go to ROTATE, busy<=1.
// - ROTATE edge: step on work_q.
//   - If rem_q <= STEP: write unbound_hv_out, out_ready<=1, busy<=0, go to IDLE.
// - Latency: max(1, ceil(k_eff/STEP)) cycles from the start edge to the out_ready-high cycle.
//   - k_eff=0 gives 1 cycle. k=63, STEP=8 gives 8 cycles.
// - out_ready is high exactly one cycle per completed operation, otherwise 0.
// - start_op while busy=1, including the final ROTATE cycle: ignored.
//   - No queueing, no effect on the in-flight result.
// - start_op in the cycle out_ready=1 (state already IDLE): accepted.
//   - k_eff <= STEP therefore gives one result per cycle back-to-back.
// - Inputs are not required stable after the accept edge.
// - unbound_hv_out changes only on a completion edge or reset.
// - Reset mid-operation: immediate clear to reset values. No out_ready for the aborted
//   operation. Next start behaves as after power-up.
// - Width rules:
//   - rem_q is SHIFT_W bits and never underflows (s <= remaining).
//   - Rotation indices are mod HV_LENGTH. k < HV_LENGTH is required by elaboration assertion.
// STRUCTURE
// - Shared package hdc_pkg:
//   - HV_LENGTH default and SHIFT_W constants.
//   - hv_t typedef logic [HV_LENGTH-1:0].
//   - unbind_state_e enum {IDLE, ROTATE}.
// - Sub-module rotate_right_step #(HV_LENGTH, STEP): combinational variable rotate-right by
//   0..STEP, a (STEP+1):1 mux per bit. One instance, input muxed between bound_hv_in
//   (IDLE) and work_q (ROTATE).
// - Top holds the FSM, rem_q, work_q and the output registers.
// TESTING
// (All tests: HV_LENGTH=1024, STEP=8, scoreboard model rotr(in,k_eff).)
// - T1: mode=0, k=37, in=random, start 1 cycle -> next cycle out_ready=1,
//   out==in, busy never high.
// - T2: mode=1, k=5, in=1<<5 -> next cycle out_ready=1, out==1<<0. Also in=1<<0
//   -> out==1<<1019.
// - T3: mode=1, k=63, in=1<<63 -> busy high 7 cycles, out_ready in cycle 8 after start,
//   out==1<<0.
// - T4: random HV, every k in 0..63: left-rotate by k in the bench, then unbind ->
//   out==original. Latency == max(1,ceil(k/8)).
// - T5: k=40 running, start with k=3 at cycle 2 -> ignored, single out_ready at cycle 5,
//   out==rotr(in,40).
//   Reset at cycle 3 of another k=40 -> all outputs 0, no out_ready. Then k=1 works in
//   1 cycle.
// - T6: start held high 10 cycles, k alternating 0/8, new in each cycle -> out_ready high
//   10 consecutive cycles, each out matches its input.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing definitions: default widths, the HV type
// and the state encoding used by the unbinding engine.
package hdc_pkg;

  localparam int HV_LENGTH_DEF = 1024;
  localparam int SHIFT_W_DEF   = 6;
  localparam int STEP_DEF      = 8;

  typedef logic [HV_LENGTH_DEF-1:0] hv_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } unbind_state_e;

endpackage

// File: rtl/rotate_right_step.sv
// Combinational rotate-right by 0..STEP positions (toward LSB):
// hv_out[i] = hv_in[(i + amt) mod HV_LENGTH]. Each output bit is a
// (STEP+1):1 mux; amounts above STEP are never presented by the caller.
module rotate_right_step #(
  parameter int HV_LENGTH = 1024,
  parameter int STEP      = 8,
  localparam int AMT_W    = $clog2(STEP + 1)
) (
  input  logic [HV_LENGTH-1:0] hv_in,
  input  logic [AMT_W-1:0]     amt,
  output logic [HV_LENGTH-1:0] hv_out
);

  // select one of the STEP+1 fixed rotations
  always_comb begin
    hv_out = hv_in;
    for (int s = 1; s <= STEP; s++) begin
      if (amt == AMT_W'(s)) begin
        hv_out = (hv_in >> s) | (hv_in << (HV_LENGTH - s));
      end
    end
  end

endmodule

// File: rtl/unbinding_op.sv
// Permutation unbinding: rotates a bound hypervector toward LSB by k to undo
// the binding rotation. A single narrow rotator is reused over several cycles,
// consuming at most STEP positions per cycle, so long shifts cost latency
// rather than a full barrel shifter.
module unbinding_op
  import hdc_pkg::*;
#(
  parameter int HV_LENGTH = HV_LENGTH_DEF,
  parameter int SHIFT_W   = SHIFT_W_DEF,
  parameter int STEP      = STEP_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [HV_LENGTH-1:0] bound_hv_in,
  input  logic                 start_op,
  input  logic                 shift_binding_mode,
  input  logic [SHIFT_W-1:0]   shift_amount,
  output logic [HV_LENGTH-1:0] unbound_hv_out,
  output logic                 out_ready,
  output logic                 busy
);

  localparam int AMT_W = $clog2(STEP + 1);

  // Parameter sanity: the largest k must stay below the vector length and the
  // per-cycle step must be representable in the shift-amount width.
  if (STEP < 1 || STEP > (2 ** SHIFT_W) - 1) begin : g_bad_step
    $error("unbinding_op: STEP must be in 1..2**SHIFT_W-1");
  end
  if ((2 ** SHIFT_W) - 1 >= HV_LENGTH) begin : g_bad_shift_w
    $error("unbinding_op: maximum shift amount must be below HV_LENGTH");
  end

  // Clamp the remaining distance to what one rotator pass can cover.
  function automatic logic [AMT_W-1:0] sat_step(input logic [SHIFT_W-1:0] rem);
    if (rem > SHIFT_W'(STEP)) begin
      return AMT_W'(STEP);
    end
    return AMT_W'(rem);
  endfunction

  unbind_state_e        state_q;
  logic [HV_LENGTH-1:0] work_q;
  logic [SHIFT_W-1:0]   rem_q;

  logic [SHIFT_W-1:0]   k_eff;
  logic [SHIFT_W-1:0]   rem_src;
  logic [SHIFT_W-1:0]   rem_next;
  logic [AMT_W-1:0]     step_amt;
  logic [HV_LENGTH-1:0] rot_in;
  logic [HV_LENGTH-1:0] rot_out;

  // operand selection: the fresh request in IDLE, the partial result in ROTATE
  always_comb begin
    k_eff    = shift_binding_mode ? shift_amount : '0;
    rem_src  = (state_q == IDLE) ? k_eff : rem_q;
    rot_in   = (state_q == IDLE) ? bound_hv_in : work_q;
    step_amt = sat_step(rem_src);
    rem_next = rem_src - SHIFT_W'(step_amt);
  end

  rotate_right_step #(
    .HV_LENGTH(HV_LENGTH),
    .STEP     (STEP)
  ) u_rot (
    .hv_in (rot_in),
    .amt   (step_amt),
    .hv_out(rot_out)
  );

  // control FSM, partial-result register and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      work_q         <= '0;
      rem_q          <= '0;
      unbound_hv_out <= '0;
      out_ready      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      out_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_op) begin
            if (rem_next == '0) begin
              unbound_hv_out <= rot_out;
              out_ready      <= 1'b1;
            end else begin
              work_q  <= rot_out;
              rem_q   <= rem_next;
              busy    <= 1'b1;
              state_q <= ROTATE;
            end
          end
        end
        ROTATE: begin
          // start_op is deliberately ignored here, including the final cycle
          if (rem_q <= SHIFT_W'(STEP)) begin
            unbound_hv_out <= rot_out;
            out_ready      <= 1'b1;
            busy           <= 1'b0;
            rem_q          <= '0;
            state_q        <= IDLE;
          end else begin
            work_q <= rot_out;
            rem_q  <= rem_next;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unbinding_op.sv
// Bench for unbinding_op: a transaction-level model (accept time, latency,
// rotr of the sampled input) predicts out_ready, busy and the held result on
// every cycle; directed sequences add literal expectations.
module tb_unbinding_op;

  localparam int N  = 1024;
  localparam int SW = 6;
  localparam int ST = 8;

  typedef logic [N-1:0] hv_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  hv_t           bound_hv_in;
  logic          start_op;
  logic          shift_binding_mode;
  logic [SW-1:0] shift_amount;
  hv_t           unbound_hv_out;
  logic          out_ready;
  logic          busy;

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  unbinding_op #(
    .HV_LENGTH(N),
    .SHIFT_W  (SW),
    .STEP     (ST)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .bound_hv_in       (bound_hv_in),
    .start_op          (start_op),
    .shift_binding_mode(shift_binding_mode),
    .shift_amount      (shift_amount),
    .unbound_hv_out    (unbound_hv_out),
    .out_ready         (out_ready),
    .busy              (busy)
  );

  always #5 clk_i = ~clk_i;

  function automatic hv_t rotr(input hv_t a, input int k);
    hv_t r;
    for (int i = 0; i < N; i++) r[i] = a[(i + k) % N];
    return r;
  endfunction

  function automatic hv_t rotl(input hv_t a, input int k);
    hv_t r;
    for (int i = 0; i < N; i++) r[i] = a[(i - k + N) % N];
    return r;
  endfunction

  function automatic hv_t rand_hv();
    hv_t r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_int(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_hv(input string nm, input hv_t act, input hv_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  int   cyc       = 0;
  int   done_edge = -1;
  hv_t  pend      = '0;
  hv_t  exp_hold  = '0;
  logic exp_rdy   = 1'b0;
  logic exp_busy  = 1'b0;

  always @(posedge clk_i) begin
    int k;
    int lat;
    cyc++;
    if (!rst_ni) begin
      done_edge = -1;
      exp_hold  = '0;
      exp_rdy   = 1'b0;
      exp_busy  = 1'b0;
    end else begin
      if (cyc > done_edge && start_op) begin
        k   = shift_binding_mode ? int'(shift_amount) : 0;
        lat = (k + ST - 1) / ST;
        if (lat < 1) lat = 1;
        done_edge = cyc + lat - 1;
        pend      = rotr(bound_hv_in, k);
      end
      exp_rdy  = (cyc == done_edge);
      if (exp_rdy) exp_hold = pend;
      exp_busy = (cyc < done_edge);
    end
  end

  always @(negedge clk_i) begin
    if (armed) begin
      check_int("sb_ready", 32'(out_ready), rst_ni ? 32'(exp_rdy) : 32'd0);
      check_int("sb_busy", 32'(busy), rst_ni ? 32'(exp_busy) : 32'd0);
      check_hv("sb_out", unbound_hv_out, rst_ni ? exp_hold : '0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic to_drive();
    @(posedge clk_i);
    #2;
  endtask

  task automatic run_op(input hv_t in, input logic mode, input int k,
                        output int lat, output hv_t val, output int bcyc);
    bound_hv_in        = in;
    shift_binding_mode = mode;
    shift_amount       = SW'(k);
    start_op           = 1'b1;
    @(posedge clk_i);
    #2;
    start_op     = 1'b0;
    bound_hv_in  = rand_hv();
    shift_amount = SW'($urandom);
    lat  = 0;
    bcyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      lat++;
      if (busy === 1'b1) bcyc++;
      if (out_ready === 1'b1) break;
    end
    check_int("op_done", 32'(out_ready), 32'd1);
    val = unbound_hv_out;
    to_drive();
  endtask

  initial begin
    hv_t one;
    hv_t a;
    hv_t b;
    hv_t val;
    int  lat;
    int  bc;
    int  cnt;
    int  rj;
    int  exp_lat;

    one = '0;
    one[0] = 1'b1;

    rst_ni             = 1'b0;
    start_op           = 1'b0;
    shift_binding_mode = 1'b0;
    shift_amount       = '0;
    bound_hv_in        = '0;
    repeat (2) @(posedge clk_i);
    armed = 1;
    #1;
    check_int("rst_ready", 32'(out_ready), 32'd0);
    check_int("rst_busy", 32'(busy), 32'd0);
    check_hv("rst_out", unbound_hv_out, '0);
    #1;
    rst_ni = 1'b1;
    to_drive();

    // model pins
    check_hv("pin_rotr5", rotr(one << 5, 5), one);
    check_hv("pin_rotr_wrap", rotr(one, 5), one << 1019);

    // T1: pass-through
    a = rand_hv();
    run_op(a, 1'b0, 37, lat, val, bc);
    check_hv("t1_out", val, a);
    check_int("t1_lat", 32'(lat), 32'd1);
    check_int("t1_busy", 32'(bc), 32'd0);

    // T2: short unbind and wraparound
    run_op(one << 5, 1'b1, 5, lat, val, bc);
    check_hv("t2_out", val, one);
    check_int("t2_lat", 32'(lat), 32'd1);
    run_op(one, 1'b1, 5, lat, val, bc);
    check_hv("t2_wrap", val, one << 1019);

    // T3: longest shift
    run_op(one << 63, 1'b1, 63, lat, val, bc);
    check_hv("t3_out", val, one);
    check_int("t3_lat", 32'(lat), 32'd8);
    check_int("t3_busy", 32'(bc), 32'd7);

    // T4: bind/unbind round trip for every k
    for (int k = 0; k < 64; k++) begin
      a = rand_hv();
      run_op(rotl(a, k), 1'b1, k, lat, val, bc);
      exp_lat = (k + 7) / 8;
      if (exp_lat < 1) exp_lat = 1;
      check_hv("t4_out", val, a);
      check_int("t4_lat", 32'(lat), 32'(exp_lat));
    end

    // T5a: start during busy is ignored
    a = rand_hv();
    bound_hv_in = a; shift_binding_mode = 1'b1; shift_amount = 6'd40; start_op = 1'b1;
    @(posedge clk_i); #2;
    bound_hv_in = rand_hv(); shift_amount = 6'd3; start_op = 1'b1;
    @(posedge clk_i); #2;
    start_op = 1'b0;
    cnt = 0; rj = 0; val = '0;
    for (int j = 2; j <= 9; j++) begin
      @(negedge clk_i);
      if (out_ready === 1'b1) begin
        cnt++;
        rj  = j;
        val = unbound_hv_out;
      end
    end
    check_int("t5_cnt", 32'(cnt), 32'd1);
    check_int("t5_cycle", 32'(rj), 32'd5);
    check_hv("t5_out", val, rotr(a, 40));
    to_drive();

    // T5b: reset mid-operation
    bound_hv_in = rand_hv(); shift_amount = 6'd40; start_op = 1'b1;
    @(posedge clk_i); #2;
    start_op = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_int("t5_rst_ready", 32'(out_ready), 32'd0);
    check_int("t5_rst_busy", 32'(busy), 32'd0);
    check_hv("t5_rst_out", unbound_hv_out, '0);
    to_drive();
    rst_ni = 1'b1;
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk_i);
      if (out_ready === 1'b1) cnt++;
    end
    check_int("t5_no_ready", 32'(cnt), 32'd0);
    to_drive();
    a = rand_hv();
    run_op(a, 1'b1, 1, lat, val, bc);
    check_hv("t5_k1_out", val, rotr(a, 1));
    check_int("t5_k1_lat", 32'(lat), 32'd1);

    // T6: start held high, back-to-back short operations
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bound_hv_in = rand_hv(); shift_binding_mode = 1'b1;
      shift_amount = (i % 2 == 1) ? 6'd8 : 6'd0; start_op = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      if (out_ready === 1'b1) cnt++;
    end
    start_op = 1'b0;
    check_int("t6_ready_run", 32'(cnt), 32'd10);
    cnt = 0;
    repeat (2) begin
      @(negedge clk_i);
      if (out_ready === 1'b1) cnt++;
    end
    check_int("t6_after", 32'(cnt), 32'd0);
    to_drive();

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst_ni             = ($urandom_range(0, 59) != 0);
      start_op           = ($urandom_range(0, 2) != 0);
      shift_binding_mode = $urandom_range(0, 1);
      shift_amount       = SW'($urandom);
      bound_hv_in        = rand_hv();
      to_drive();
    end
    rst_ni   = 1'b1;
    start_op = 1'b0;
    repeat (12) to_drive();

    b = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule
